// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at issue, captures CDB results, retires in program order.
// Optional ROB_CDB_BYPASS_EN forwards a same-cycle CDB broadcast onto the lookup outputs.
module reorder_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              lookup_done,
    output logic [DATA_W-1:0] lookup_value,
    output logic              commit_valid,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_value,
    output logic [TAG_W-1:0]  commit_tag,
    input  logic              flush,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0] L_DEPTH = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_done;
    logic [REG_W-1:0]  r_rd    [DEPTH];
    logic [DATA_W-1:0] r_value [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic w_alloc_fire;
    logic w_cdb_fire;
    logic w_retire_fire;

    // alloc_ready looks only at the registered count; a same-edge retire never frees a slot early
    assign alloc_ready   = (r_count < L_DEPTH);
    assign alloc_tag     = r_tail;
    assign count         = r_count;
    assign w_alloc_fire  = alloc_valid && alloc_ready;
    assign w_cdb_fire    = cdb_valid && r_busy[cdb_tag];
    assign w_retire_fire = r_busy[r_head] && r_done[r_head];

    // Operand lookup for renaming
    always_comb begin
        lookup_done  = r_busy[lookup_tag] && r_done[lookup_tag];
        lookup_value = lookup_done ? r_value[lookup_tag] : '0;
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && (cdb_tag == lookup_tag) && r_busy[lookup_tag]) begin
            lookup_done  = 1'b1;
            lookup_value = cdb_value;
        end
`endif
    end

    // Entry state, pointers, occupancy and registered commit port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_done       <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_tag   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_rd[i]    <= '0;
                r_value[i] <= '0;
            end
        end else if (flush) begin
            r_busy       <= '0;
            r_done       <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            commit_valid <= 1'b0;
        end else begin
            if (w_cdb_fire) begin
                r_value[cdb_tag] <= cdb_value;
                r_done[cdb_tag]  <= 1'b1;
            end
            if (w_alloc_fire) begin
                r_busy[r_tail]  <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_rd[r_tail]    <= alloc_rd;
                r_value[r_tail] <= '0;
                r_tail          <= r_tail + TAG_W'(1);
            end
            // Retire last so it wins over a repeated CDB write to the head slot
            if (w_retire_fire) begin
                commit_rd      <= r_rd[r_head];
                commit_value   <= r_value[r_head];
                commit_tag     <= r_head;
                r_busy[r_head] <= 1'b0;
                r_done[r_head] <= 1'b0;
                r_head         <= r_head + TAG_W'(1);
            end
            commit_valid <= w_retire_fire;
            case ({w_alloc_fire, w_retire_fire})
                2'b10:   r_count <= r_count + (TAG_W+1)'(1);
                2'b01:   r_count <= r_count - (TAG_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic against a queue model.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [2:0]  lookup_tag;
    logic        lookup_done;
    logic [31:0] lookup_value;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [2:0]  commit_tag;
    logic        flush;
    logic [3:0]  count;

    reorder_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .lookup_tag(lookup_tag), .lookup_done(lookup_done), .lookup_value(lookup_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_tag(commit_tag), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        done;
        logic [31:0] value;
    } ent_t;

    // Model: program-ordered queue of in-flight instructions; oldest has tag m_head
    ent_t        mq[$];
    int          m_head;
    logic        e_cv;
    logic [4:0]  e_crd;
    logic [31:0] e_cval;
    logic [2:0]  e_ctag;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_head = 0;
        e_cv = 1'b0; e_crd = '0; e_cval = '0; e_ctag = '0;
    endtask

    // One clock: drive, check combinational outputs, advance model, check registered outputs
    task automatic step(input logic av, input logic [4:0] rd, input logic cv, input logic [2:0] ct,
                        input logic [31:0] cval, input logic fl, input logic [2:0] lt);
        int   lidx, cidx;
        logic lbusy, ed;
        logic [31:0] ev;
        logic do_ret, do_alloc;
        ent_t ne;
        @(negedge clk);
        alloc_valid = av; alloc_rd = rd; cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
        flush = fl; lookup_tag = lt;
        #1;
        chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < 8));
        chk("alloc_tag", 32'(alloc_tag), 32'((m_head + mq.size()) % 8));
        lidx  = (int'(lt) - m_head + 8) % 8;
        lbusy = lidx < mq.size();
        ed    = lbusy && mq[lidx].done;
        ev    = ed ? mq[lidx].value : 32'h0;
`ifdef ROB_CDB_BYPASS_EN
        if (cv && ct == lt && lbusy) begin
            ed = 1'b1;
            ev = cval;
        end
`endif
        chk("lookup_done", 32'(lookup_done), 32'(ed));
        chk("lookup_value", lookup_value, ev);

        if (fl) begin
            mq.delete();
            m_head = 0;
            e_cv = 1'b0;
        end else begin
            do_ret   = mq.size() > 0 && mq[0].done;
            do_alloc = av && mq.size() < 8;
            if (do_ret) begin
                e_crd = mq[0].rd; e_cval = mq[0].value; e_ctag = 3'(m_head);
            end
            e_cv = do_ret;
            cidx = (int'(ct) - m_head + 8) % 8;
            if (cv && cidx < mq.size()) begin
                mq[cidx].done  = 1'b1;
                mq[cidx].value = cval;
            end
            if (do_ret) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % 8;
            end
            if (do_alloc) begin
                ne.rd = rd; ne.done = 1'b0; ne.value = 32'h0;
                mq.push_back(ne);
            end
        end
        @(posedge clk);
        #1;
        chk("commit_valid", 32'(commit_valid), 32'(e_cv));
        chk("commit_rd", 32'(commit_rd), 32'(e_crd));
        chk("commit_value", commit_value, e_cval);
        chk("commit_tag", 32'(commit_tag), 32'(e_ctag));
        chk("count", 32'(count), 32'(mq.size()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_commit_valid"}, 32'(commit_valid), 32'd0);
        chk({tag, "_alloc_ready"}, 32'(alloc_ready), 32'd1);
        chk({tag, "_alloc_tag"}, 32'(alloc_tag), 32'd0);
        chk({tag, "_lookup_done"}, 32'(lookup_done), 32'd0);
        chk({tag, "_commit_value"}, commit_value, 32'd0);
    endtask

    initial begin
        int pick;
        logic [2:0] rtag;
        rst_n = 1'b0;
        alloc_valid = 1'b0; alloc_rd = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        flush = 1'b0; lookup_tag = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Three allocations, then out-of-order completion of tags 1 and 0
        step(1'b1, 5'd5, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        step(1'b1, 5'd6, 1'b0, 3'd0, 32'h0, 1'b0, 3'd1);
        step(1'b1, 5'd7, 1'b0, 3'd0, 32'h0, 1'b0, 3'd2);
        chk("three_alloc_count", 32'(count), 32'd3);
        step(1'b0, 5'd0, 1'b1, 3'd1, 32'h22, 1'b0, 3'd1);
        step(1'b0, 5'd0, 1'b1, 3'd0, 32'h11, 1'b0, 3'd0);
        step(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        chk("first_commit_value", commit_value, 32'h11);
        step(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        chk("second_commit_value", commit_value, 32'h22);
        idle(2);
        chk("tag2_pending_count", 32'(count), 32'd1);

        // Fill to full, overflow attempt, retire with alloc held, then wrap
        step(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 5'(i + 10), 1'b0, 3'd0, 32'h0, 1'b0, 3'(i));
        chk("full_count", 32'(count), 32'd8);
        step(1'b1, 5'd31, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        step(1'b1, 5'd30, 1'b1, 3'd0, 32'hABCD, 1'b0, 3'd0);
        step(1'b1, 5'd29, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        step(1'b1, 5'd28, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        chk("wrap_count", 32'(count), 32'd8);

        // Lookup racing a CDB broadcast, then flush with a CDB in flight
        step(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 5'(i + 1), 1'b0, 3'd0, 32'h0, 1'b0, 3'd3);
        step(1'b0, 5'd0, 1'b1, 3'd3, 32'hDEAD, 1'b0, 3'd3);
        step(1'b0, 5'd0, 1'b1, 3'd3, 32'hBEEF, 1'b0, 3'd3);
        step(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd3);
        step(1'b0, 5'd0, 1'b1, 3'd2, 32'h5555, 1'b1, 3'd2);
        chk("flush_count", 32'(count), 32'd0);
        step(1'b1, 5'd9, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);

        // Random traffic; CDB tags mostly aimed at in-flight entries
        for (int n = 0; n < 600; n++) begin
            pick = mq.size() > 0 ? int'($urandom_range(0, mq.size() - 1)) : 0;
            rtag = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'((m_head + pick) % 8);
            step($urandom_range(0, 9) < 6, 5'($urandom), $urandom_range(0, 9) < 6, rtag,
                 $urandom, $urandom_range(0, 49) == 0, 3'($urandom));
        end

        // Asynchronous reset in the middle of a retire
        step(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0);
        step(1'b1, 5'd3, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        step(1'b1, 5'd4, 1'b1, 3'd0, 32'h77, 1'b0, 3'd0);
        @(negedge clk);
        alloc_valid = 1'b0; cdb_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5'd8, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
